// File: rtl/field_ordering_check_pkg.sv
// field_ordering_check_pkg: shared defaults and FSM encoding for the field-ordering check
package field_ordering_check_pkg;
  localparam int M_DEF = 13;
  localparam int SIGMA2_DEF = 32;
  localparam int N_DEF = 6688;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/field_ordering_check_bitrev.sv
// bitrev: combinational W-bit reversal (bit j -> bit W-1-j)
module bitrev #(
  parameter int W = 13
) (
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  for (genvar i = 0; i < W; i++) begin : g_rev
    assign q[i] = d[W-1-i];
  end
endmodule

// File: rtl/field_ordering_check.sv
// field_ordering_check: scans sorted words for adjacent duplicates and emits bit-reversed support
module field_ordering_check
  import field_ordering_check_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int SIGMA2 = SIGMA2_DEF,
  parameter int N = N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              rd_en,
  output logic [M-1:0]      rd_addr,
  input  logic [SIGMA2-1:0] rand_din,
  input  logic [M-1:0]      index_din,
  output logic              sup_wr_en,
  output logic [M-1:0]      sup_wr_addr,
  output logic [M-1:0]      sup_dout
);
  localparam logic [M:0] NLIM = (M+1)'(N);
  state_t state, state_nx;
  logic last, vld, first_flag;
  logic [M-1:0] tag, rev;
  logic [SIGMA2-1:0] prev_word;
  assign last = rd_addr == '1;
  assign rd_en = state == READ;
  assign busy = state == READ || state == DRAIN;
  assign done = state == DONE;
  bitrev #(.W(M)) u_bitrev (.d(index_din), .q(rev));
  // DRAIN waits until the last read's data has been consumed by the pipeline stage
  always_comb begin
    state_nx = (state == IDLE && start) ? READ :
               (state == READ && last)  ? DRAIN :
               (state == DRAIN && !vld) ? DONE :
               (state == DONE)          ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      vld <= 1'b0;
      tag <= '0;
      first_flag <= 1'b0;
      prev_word <= '0;
      fail <= 1'b0;
      sup_wr_en <= 1'b0;
      sup_wr_addr <= '0;
      sup_dout <= '0;
    end else begin
      rd_addr <= (rd_en && !last) ? rd_addr + 1'b1 : '0;
      vld <= rd_en;
      tag <= rd_addr;
      sup_wr_en <= vld && ({1'b0, tag} < NLIM);
      if (vld) begin
        sup_wr_addr <= tag;
        sup_dout <= rev;
        prev_word <= rand_din;
        first_flag <= 1'b0;
        fail <= fail | (!first_flag && rand_din == prev_word);
      end
      if (state == IDLE && start) begin
        fail <= 1'b0;
        first_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_field_ordering_check.sv
// tb_field_ordering_check: directed checks of field_ordering_check with M=4, SIGMA2=8, N=12
module tb_field_ordering_check;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, fail, rd_en, sup_wr_en;
  logic [3:0] rd_addr, index_din, sup_wr_addr, sup_dout;
  logic [7:0] rand_din;
  logic [7:0] rom_w [16];
  logic [3:0] rom_i [16];
  logic [3:0] wa [32];
  logic [3:0] wd [32];
  logic [3:0] exp_sup [12] = '{4'hF, 4'h7, 4'hB, 4'h3, 4'hD, 4'h5, 4'h9, 4'h1, 4'hE, 4'h6, 4'hA, 4'h2};
  logic [3:0] last_rd;
  int nw, ndone, pass, total;
  bit addr_err, seen_rd;
  int lat;
  logic f_done, f_c1, b_done;

  field_ordering_check #(.M(4), .SIGMA2(8), .N(12)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .rd_en(rd_en), .rd_addr(rd_addr), .rand_din(rand_din), .index_din(index_din),
    .sup_wr_en(sup_wr_en), .sup_wr_addr(sup_wr_addr), .sup_dout(sup_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rand_din <= rom_w[rd_addr];
    index_din <= rom_i[rd_addr];
  end

  always @(negedge clk) begin
    if (sup_wr_en) begin
      if (nw < 32) begin
        wa[nw] = sup_wr_addr;
        wd[nw] = sup_dout;
      end
      nw++;
    end
    if (done) ndone++;
    if (rd_en) begin
      if (seen_rd && rd_addr != last_rd + 4'd1) addr_err = 1;
      last_rd = rd_addr;
      seen_rd = 1;
    end
  end

  task automatic load_rom(input int dup_at);
    for (int i = 0; i < 16; i++) begin
      rom_w[i] = 8'(i + 1);
      rom_i[i] = 4'(15 - i);
    end
    if (dup_at >= 0) rom_w[dup_at + 1] = rom_w[dup_at];
  endtask

  task automatic do_scan(input int restart_at, input int rst_at, output int l,
                         output logic fd, output logic fc1, output logic bd);
    l = 0; fd = 1'bx; fc1 = 1'bx; bd = 1'bx;
    @(negedge clk);
    nw = 0; ndone = 0; addr_err = 0; seen_rd = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == 1) fc1 = fail;
      if (c == rst_at) begin
        rst = 1;
        return;
      end
      if (done) begin
        l = c; fd = fail; bd = busy;
        break;
      end
    end
    start = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    if ({busy, done, fail, rd_en, sup_wr_en} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {busy, done, fail, rd_en, sup_wr_en});
    else pass++;
    total++;
    if ({rd_addr, sup_wr_addr, sup_dout} !== 12'h0) $display("FAIL reset_addr: got %h want 000", {rd_addr, sup_wr_addr, sup_dout});
    else pass++;
    total++;
    rst = 0;
  endtask

  task automatic test_pass;
    load_rom(-1);
    do_scan(0, 0, lat, f_done, f_c1, b_done);
    if (lat !== 18) $display("FAIL pass_latency: got %0d want 18", lat); else pass++;
    total++;
    if (f_done !== 1'b0) $display("FAIL pass_fail: got %b want 0", f_done); else pass++;
    total++;
    if (b_done !== 1'b0) $display("FAIL pass_busy_at_done: got %b want 0", b_done); else pass++;
    total++;
    if (nw !== 12) $display("FAIL pass_nwrites: got %0d want 12", nw); else pass++;
    total++;
    for (int i = 0; i < 12; i++) begin
      if (wa[i] !== 4'(i) || wd[i] !== exp_sup[i])
        $display("FAIL pass_write%0d: got addr %h data %h want addr %h data %h", i, wa[i], wd[i], 4'(i), exp_sup[i]);
      else pass++;
      total++;
    end
    repeat (3) @(negedge clk);
    if (ndone !== 1) $display("FAIL pass_done_count: got %0d want 1", ndone); else pass++;
    total++;
  endtask

  task automatic test_dup_tail;
    load_rom(14);
    do_scan(0, 0, lat, f_done, f_c1, b_done);
    if (lat !== 18 || f_done !== 1'b1) $display("FAIL tail_dup: got lat %0d fail %b want 18 1", lat, f_done); else pass++;
    total++;
    if (nw !== 12) $display("FAIL tail_nwrites: got %0d want 12", nw); else pass++;
    total++;
  endtask

  task automatic test_head;
    load_rom(0);
    do_scan(0, 0, lat, f_done, f_c1, b_done);
    if (f_done !== 1'b1) $display("FAIL head_dup: got %b want 1", f_done); else pass++;
    total++;
    load_rom(-1);
    rom_w[0] = 8'h00;
    do_scan(0, 0, lat, f_done, f_c1, b_done);
    if (f_done !== 1'b0 || lat !== 18) $display("FAIL zero_first: got fail %b lat %0d want 0 18", f_done, lat); else pass++;
    total++;
  endtask

  task automatic test_restart;
    load_rom(-1);
    do_scan(5, 0, lat, f_done, f_c1, b_done);
    if (lat !== 18) $display("FAIL restart_latency: got %0d want 18", lat); else pass++;
    total++;
    if (addr_err !== 1'b0) $display("FAIL restart_addr_seq: got %b want 0", addr_err); else pass++;
    total++;
    repeat (4) @(negedge clk);
    if (ndone !== 1) $display("FAIL restart_done_count: got %0d want 1", ndone); else pass++;
    total++;
  endtask

  task automatic test_reset_mid;
    load_rom(3);
    do_scan(0, 9, lat, f_done, f_c1, b_done);
    #1;
    if ({busy, done, fail, rd_en, sup_wr_en} !== 5'b0) $display("FAIL midrst_ctrl: got %b want 00000", {busy, done, fail, rd_en, sup_wr_en});
    else pass++;
    total++;
    if ({rd_addr, sup_wr_addr, sup_dout} !== 12'h0) $display("FAIL midrst_addr: got %h want 000", {rd_addr, sup_wr_addr, sup_dout});
    else pass++;
    total++;
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    if (ndone !== 0) $display("FAIL midrst_no_done: got %0d want 0", ndone); else pass++;
    total++;
    load_rom(-1);
    do_scan(0, 0, lat, f_done, f_c1, b_done);
    if (lat !== 18 || f_done !== 1'b0) $display("FAIL midrst_rescan: got lat %0d fail %b want 18 0", lat, f_done); else pass++;
    total++;
  endtask

  task automatic test_back_to_back;
    load_rom(7);
    do_scan(0, 0, lat, f_done, f_c1, b_done);
    if (f_done !== 1'b1) $display("FAIL b2b_first_fail: got %b want 1", f_done); else pass++;
    total++;
    load_rom(-1);
    do_scan(0, 0, lat, f_done, f_c1, b_done);
    if (f_c1 !== 1'b0) $display("FAIL b2b_fail_cleared: got %b want 0", f_c1); else pass++;
    total++;
    if (f_done !== 1'b0 || lat !== 18) $display("FAIL b2b_second: got fail %b lat %0d want 0 18", f_done, lat); else pass++;
    total++;
  endtask

  initial begin
    load_rom(-1);
    test_reset;
    test_pass;
    test_dup_tail;
    test_head;
    test_restart;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
